// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_num_t;
  typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;

  // Index of the hardwired zero register.
  localparam int unsigned ZERO_IDX = 32'd0;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register plus a registered population count.
// A mark on the same edge as a retiring write to the same register wins, because
// the mark belongs to a newer producer than the write that is retiring.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int WRITE_PORTS = 2,
  parameter int ZERO_REG    = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] write_num,
  input  logic [WRITE_PORTS-1:0]            write_en,
  input  logic [ADDR_WIDTH-1:0]             mark_num,
  input  logic                              mark_en,
  output logic [(2**ADDR_WIDTH)-1:0]        pending,
  output logic [ADDR_WIDTH:0]               pending_count
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_NUM = ADDR_WIDTH'(ZERO_IDX);

  logic [DEPTH-1:0]  pending_q;
  logic [DEPTH-1:0]  pending_d;
  logic [ADDR_WIDTH:0] count_q;
  logic [ADDR_WIDTH:0] count_d;

  // Next pending vector: clears from retiring writes first, then the new mark.
  always_comb begin
    pending_d = pending_q;
    for (int p = 0; p < WRITE_PORTS; p++) begin
      if (write_en[p]) begin
        pending_d[write_num[p*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
      end else begin
        pending_d = pending_d;
      end
    end
    if (mark_en) begin
      pending_d[mark_num] = 1'b1;
    end else begin
      pending_d = pending_d;
    end
    if ((ZERO_REG != 32'sd0) && (DEPTH > 1)) begin
      pending_d[ZERO_NUM] = 1'b0;
    end else begin
      pending_d = pending_d;
    end
  end

  // Population count of the next pending vector, registered alongside the bits.
  always_comb begin
    count_d = {(ADDR_WIDTH+1){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + (ADDR_WIDTH+1)'(pending_d[i]);
    end
  end

  // Pending bits and count register; reset discards any same-cycle marks/clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= {DEPTH{1'b0}};
      count_q   <= {(ADDR_WIDTH+1){1'b0}};
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign pending       = pending_q;
  assign pending_count = count_q;

endmodule : regfile_scoreboard

// File: rtl/regfile_mp.sv
// Multi-port register file: asynchronous reads, synchronous writes with
// highest-port priority, optional same-cycle write bypass, optional zero register,
// and a pending-write scoreboard for the pipeline.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2,
  parameter int ZERO_REG    = 1,
  parameter int BYPASS      = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0]  read_num,
  output logic [READ_PORTS*DATA_WIDTH-1:0]  read_data,
  output logic [READ_PORTS-1:0]             read_pending,
  input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] write_num,
  input  logic [WRITE_PORTS*DATA_WIDTH-1:0] write_data,
  input  logic [WRITE_PORTS-1:0]            write_en,
  input  logic [ADDR_WIDTH-1:0]             mark_num,
  input  logic                              mark_en,
  output logic [ADDR_WIDTH:0]               pending_count
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_NUM = ADDR_WIDTH'(ZERO_IDX);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]      pending_s;

  regfile_scoreboard #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .WRITE_PORTS (WRITE_PORTS),
    .ZERO_REG    (ZERO_REG)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .write_num     (write_num),
    .write_en      (write_en),
    .mark_num      (mark_num),
    .mark_en       (mark_en),
    .pending       (pending_s),
    .pending_count (pending_count)
  );

  // Next storage contents: later (higher-numbered) ports overwrite earlier ones.
  always_comb begin
    mem_d = mem_q;
    for (int p = 0; p < WRITE_PORTS; p++) begin
      if (write_en[p] &&
          !((ZERO_REG != 32'sd0) && (write_num[p*ADDR_WIDTH +: ADDR_WIDTH] == ZERO_NUM))) begin
        mem_d[write_num[p*ADDR_WIDTH +: ADDR_WIDTH]] = write_data[p*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        mem_d = mem_d;
      end
    end
  end

  // Storage array register, cleared by reset regardless of same-cycle writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar r = 0; r < READ_PORTS; r++) begin : g_read
    logic [ADDR_WIDTH-1:0] rnum_s;
    logic [DATA_WIDTH-1:0] rdata_s;
    logic                  rpend_s;

    assign rnum_s = read_num[r*ADDR_WIDTH +: ADDR_WIDTH];

    // Read mux: stored value, then optional forwarding, then zero-register override.
    always_comb begin
      rdata_s = mem_q[rnum_s];
      rpend_s = pending_s[rnum_s];
      if (BYPASS != 32'sd0) begin
        for (int p = 0; p < WRITE_PORTS; p++) begin
          if (write_en[p] && (write_num[p*ADDR_WIDTH +: ADDR_WIDTH] == rnum_s)) begin
            rdata_s = write_data[p*DATA_WIDTH +: DATA_WIDTH];
            rpend_s = mark_en && (mark_num == rnum_s);
          end else begin
            rdata_s = rdata_s;
          end
        end
      end else begin
        rdata_s = rdata_s;
      end
      if ((ZERO_REG != 32'sd0) && (rnum_s == ZERO_NUM)) begin
        rdata_s = {DATA_WIDTH{1'b0}};
        rpend_s = 1'b0;
      end else begin
        rdata_s = rdata_s;
      end
    end

    assign read_data[r*DATA_WIDTH +: DATA_WIDTH] = rdata_s;
    assign read_pending[r]                       = rpend_s;
  end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one instance with bypass, one without,
// both driven by the same stimulus.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic        clk;
  logic        rst;
  logic [9:0]  read_num;
  logic [63:0] read_data_b;
  logic [63:0] read_data_n;
  logic [1:0]  read_pending_b;
  logic [1:0]  read_pending_n;
  logic [9:0]  write_num;
  logic [63:0] write_data;
  logic [1:0]  write_en;
  logic [4:0]  mark_num;
  logic        mark_en;
  logic [5:0]  pending_count_b;
  logic [5:0]  pending_count_n;

  int compared;
  int mismatched;

  regfile_mp #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .read_num(read_num), .read_data(read_data_b),
    .read_pending(read_pending_b), .write_num(write_num), .write_data(write_data),
    .write_en(write_en), .mark_num(mark_num), .mark_en(mark_en),
    .pending_count(pending_count_b)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .read_num(read_num), .read_data(read_data_n),
    .read_pending(read_pending_n), .write_num(write_num), .write_data(write_data),
    .write_en(write_en), .mark_num(mark_num), .mark_en(mark_en),
    .pending_count(pending_count_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_en = 2'b00;
    mark_en  = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    read_num   = 10'd0;
    write_num  = 10'd0;
    write_data = 64'd0;
    write_en   = 2'b00;
    mark_num   = 5'd0;
    mark_en    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state on every index, both read ports
    chk("rst_count", {58'd0, pending_count_b}, 64'd0);
    for (int i = 0; i < 32; i++) begin
      read_num = {5'(31 - i), 5'(i)};
      #1;
      chk("rst_read", read_data_b, 64'd0);
      chk("rst_pend", {62'd0, read_pending_b}, 64'd0);
    end

    // Write reg 5 on port 0, read same cycle
    read_num   = {5'd0, 5'd5};
    write_num  = {5'd0, 5'd5};
    write_data = {32'd0, 32'hDEADBEEF};
    write_en   = 2'b01;
    #1;
    chk("byp_r5", {32'd0, read_data_b[31:0]}, 64'h0000_0000_DEAD_BEEF);
    chk("nobyp_r5_pre", {32'd0, read_data_n[31:0]}, 64'd0);
    tick();
    idle();
    #1;
    chk("byp_r5_post", {32'd0, read_data_b[31:0]}, 64'h0000_0000_DEAD_BEEF);
    chk("nobyp_r5_post", {32'd0, read_data_n[31:0]}, 64'h0000_0000_DEAD_BEEF);

    // Both ports write reg 7: port 1 wins
    read_num   = {5'd7, 5'd7};
    write_num  = {5'd7, 5'd7};
    write_data = {32'h22222222, 32'h11111111};
    write_en   = 2'b11;
    #1;
    chk("byp_r7_prio", read_data_b, 64'h2222_2222_2222_2222);
    chk("nobyp_r7_pre", read_data_n, 64'd0);
    tick();
    idle();
    #1;
    chk("r7_prio", read_data_b, 64'h2222_2222_2222_2222);
    chk("nobyp_r7_prio", read_data_n, 64'h2222_2222_2222_2222);

    // Write and mark reg 0: ignored
    read_num   = {5'd0, 5'd0};
    write_num  = {5'd0, 5'd0};
    write_data = {32'd0, 32'hFFFFFFFF};
    write_en   = 2'b01;
    mark_num   = 5'd0;
    mark_en    = 1'b1;
    #1;
    chk("r0_byp", read_data_b, 64'd0);
    chk("r0_pend_byp", {62'd0, read_pending_b}, 64'd0);
    tick();
    idle();
    #1;
    chk("r0_read", read_data_n, 64'd0);
    chk("r0_count", {58'd0, pending_count_b}, 64'd0);

    // Mark reg 3
    read_num = {5'd3, 5'd3};
    mark_num = 5'd3;
    mark_en  = 1'b1;
    #1;
    chk("m3_pre", {62'd0, read_pending_b}, 64'd0);
    tick();
    chk("m3_count", {58'd0, pending_count_b}, 64'd1);
    chk("m3_pend", {62'd0, read_pending_n}, 64'd3);
    // Write and mark reg 3 together: set wins
    write_num  = {5'd0, 5'd3};
    write_data = {32'd0, 32'h33333333};
    write_en   = 2'b01;
    #1;
    chk("m3_wm_byp_pend", {62'd0, read_pending_b}, 64'd3);
    chk("m3_wm_byp_data", {32'd0, read_data_b[31:0]}, 64'h0000_0000_3333_3333);
    tick();
    chk("m3_wm_count", {58'd0, pending_count_b}, 64'd1);
    chk("m3_wm_pend", {62'd0, read_pending_n}, 64'd3);
    // Write reg 3 alone: retires
    mark_en    = 1'b0;
    write_data = {32'd0, 32'h44444444};
    #1;
    chk("m3_w_byp_pend", {62'd0, read_pending_b}, 64'd0);
    chk("m3_w_nobyp_pend", {62'd0, read_pending_n}, 64'd3);
    tick();
    idle();
    #1;
    chk("m3_clr_count", {58'd0, pending_count_n}, 64'd0);
    chk("m3_clr_pend", {62'd0, read_pending_b}, 64'd0);
    chk("m3_data", {32'd0, read_data_n[31:0]}, 64'h0000_0000_4444_4444);

    // Mark 1, 2, 4 over three cycles
    mark_en  = 1'b1;
    mark_num = 5'd1;
    tick();
    chk("cnt1", {58'd0, pending_count_b}, 64'd1);
    mark_num = 5'd2;
    tick();
    chk("cnt2", {58'd0, pending_count_b}, 64'd2);
    mark_num = 5'd4;
    tick();
    chk("cnt3", {58'd0, pending_count_b}, 64'd3);
    read_num = {5'd4, 5'd1};
    #1;
    chk("pend_1_4", {62'd0, read_pending_n}, 64'd3);

    // Reset with a concurrent write and mark
    rst        = 1'b1;
    mark_num   = 5'd6;
    write_num  = {5'd0, 5'd9};
    write_data = {32'd0, 32'h99999999};
    write_en   = 2'b01;
    tick();
    rst = 1'b0;
    idle();
    read_num = {5'd5, 5'd9};
    #1;
    chk("rst_mid_count", {58'd0, pending_count_b}, 64'd0);
    chk("rst_mid_r9_r5", read_data_b, 64'd0);
    chk("rst_mid_pend", {62'd0, read_pending_n}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_regfile_mp

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the MIPS core, the successor of the 2-read/1-write `regfile`. It provides a configurable number of asynchronous read ports and synchronous write ports, optional write-to-read bypass, and a hardwired zero register. A per-register pending scoreboard lets the pipeline track in-flight writes. It sits between decode (reads and scoreboard marks) and writeback (writes and scoreboard clears).

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- READ_PORTS, 2, number of read ports (1..4)
- WRITE_PORTS, 2, number of write ports (1..2)
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes and marks
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching reads

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- read_num  in  READ_PORTS×ADDR_WIDTH  read indices, packed, port 0 in LSBs
- read_data  out  READ_PORTS×DATA_WIDTH  read data, combinational
- read_pending  out  READ_PORTS  pending bit of each read index, combinational
- write_num  in  WRITE_PORTS×ADDR_WIDTH  write indices
- write_data  in  WRITE_PORTS×DATA_WIDTH  write data
- write_en  in  WRITE_PORTS  per-port write enable
- mark_num  in  ADDR_WIDTH  register to mark pending
- mark_en  in  1  mark request
- pending_count  out  ADDR_WIDTH+1  number of registers currently pending

## Operation
- Reset: all registers 0, all pending bits 0; pending_count 0; read_data reads 0 for every index after the reset edge.
- Write: on rising edge with write_en[p]=1, reg[write_num[p]] ← write_data[p]. Same index on two ports: higher-numbered port wins.
- Write to index 0 with ZERO_REG=1: discarded, no pending change.
- Read: read_data[r] = reg[read_num[r]] combinationally. ZERO_REG=1 and index 0 → 0 regardless of bypass.
- Bypass (BYPASS=1): if any enabled write port targets read_num[r] this cycle, read_data[r] = that write_data (highest port wins); read_pending[r] = 0 unless mark_en targets the same index. BYPASS=0: reads see pre-edge contents.
- Scoreboard: enabled write clears pending[write_num]; mark_en sets pending[mark_num]. Same edge, same index: set wins (new producer issued after old one retires).
- pending_count: population count of pending bits, registered, updated same edge as bits.
- rst asserted mid-operation: writes and marks in that cycle are ignored; state cleared.

## Timing
- Read latency 0 cycles (combinational from read_num / write inputs).
- Write latency 1 edge; visible without bypass 1 cycle after write_en.
- Mark visible on read_pending and pending_count 1 cycle after mark_en.
- No handshake; every request accepted every cycle.

## Structure
- Package `regfile_pkg`: default widths, `reg_num_t`/`reg_data_t` typedefs, `ZERO_IDX` constant.
- Sub-module `regfile_scoreboard`: pending bit vector, set/clear priority, pending_count.
- Top holds storage array, write-port priority, bypass muxes.

## Test plan
- Reset then read all 32 indices on both ports → all 0, read_pending 0, pending_count 0.
- Write port 0 reg 5 = 0xDEADBEEF, read reg 5 same cycle → BYPASS=1: 0xDEADBEEF; BYPASS=0: 0 then 0xDEADBEEF next cycle.
- Both ports write reg 7 (0x11111111 port 0, 0x22222222 port 1) → reg 7 reads 0x22222222.
- Write reg 0 = 0xFFFFFFFF and mark reg 0 → reg 0 reads 0, pending_count stays 0.
- Mark reg 3, next cycle write reg 3 and mark reg 3 together → read_pending for 3 remains 1, pending_count 1; then write reg 3 alone → pending 0, count 0.
- Mark regs 1,2,4 over three cycles, assert rst with a write to reg 9 → pending_count 0, reg 9 reads 0.
